piso_deb_stream: RTL

- Parametrised debug parallel-in/serial-out streamer, the successor to the fixed 12-byte debug PISO.
- Takes a snapshot of a flattened debug bus of NUM_WORDS words, each W bits wide.
- Streams the snapshot out one word at a time over a valid/ready handshake.
- Supports one-shot and continuous (auto-recapture) modes.
- Sits between the NPU status/datapath taps (SSFR, control signals, MAC results, data lanes) and the debug output pins or debug bridge.

---
 rtl/npu_dbg_pkg.sv | 32 +++
 rtl/piso_deb_chk.sv | 35 +++
 rtl/piso_deb_stream.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/npu_dbg_pkg.sv
// Shared definitions for the NPU debug streamers: state encoding, default
// geometry and the word-order helper used to pick word k out of a flat bus.
package npu_dbg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOADED = 2'd1,
      ST_SHIFT  = 2'd2,
      ST_CHK    = 2'd3
   } dbg_state_e;

   localparam int DBG_NUM_WORDS = 12;
   localparam int DBG_W         = 8;

   // Widest geometry word_sel can serve; callers zero-extend into these.
   localparam int DBG_MAX_WORDS = 64;
   localparam int DBG_MAX_W     = 32;

   typedef logic [DBG_MAX_WORDS*DBG_MAX_W-1:0] dbg_bus_t;
   typedef logic [DBG_MAX_W-1:0]               dbg_word_t;

   // Word 0 lives in the most significant slot of the bus.
   function automatic dbg_word_t word_sel(input dbg_bus_t    bus,
                                          input int unsigned k,
                                          input int unsigned num_words,
                                          input int unsigned w);
      dbg_bus_t sh;
      sh = bus >> ((num_words - 1 - k) * w);
      return sh[DBG_MAX_W-1:0];
   endfunction

endpackage

// File: rtl/piso_deb_chk.sv
// W-bit running XOR accumulator with synchronous clear (clear wins over
// enable); builds the frame checksum word by word.
module piso_deb_chk #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] acc_o
);

   logic [W-1:0] acc_q, acc_d;

   always_comb begin
      acc_d = acc_q;
      if (clr_i) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = acc_q ^ din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/piso_deb_stream.sv
// Debug snapshot PISO: captures NUM_WORDS x W bits and streams word 0 first
// over valid/ready. Define PISO_DEB_CHKSUM_EN to append an XOR checksum word.
module piso_deb_stream
   import npu_dbg_pkg::*;
#(
   parameter int NUM_WORDS = DBG_NUM_WORDS,
   parameter int W         = DBG_W,
   parameter int IDX_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic                   CLKEXT,
   input  logic                   RST_GLO,
   input  logic                   EN,
   input  logic                   CLR,
   input  logic                   CAPTURE,
   input  logic                   START,
   input  logic                   CONT_MODE,
   input  logic [NUM_WORDS*W-1:0] SNAP_IN,
   output logic [W-1:0]           D_OUT,
   output logic                   D_VALID,
   input  logic                   D_READY,
   output logic                   D_LAST,
   output logic [IDX_W-1:0]       WORD_IDX,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int BUS_W = NUM_WORDS * W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
`ifdef PISO_DEB_CHKSUM_EN
   localparam logic [IDX_W-1:0] LAST_OUT_IDX = IDX_W'(NUM_WORDS);
`else
   localparam logic [IDX_W-1:0] LAST_OUT_IDX = LAST_IDX;
`endif

   // W is limited to DBG_MAX_W by the shared helper.
   function automatic logic [W-1:0] pick(input logic [BUS_W-1:0] bus,
                                         input logic [IDX_W-1:0] k);
      dbg_bus_t  ext;
      dbg_word_t wd;
      ext = '0;
      ext[BUS_W-1:0] = bus;
      wd = word_sel(ext, 32'(k), NUM_WORDS, W);
      return wd[W-1:0];
   endfunction

   dbg_state_e       state_q;
   logic [BUS_W-1:0] snap_q;
   logic [W-1:0]     dout_q;
   logic             dvalid_q;
   logic [IDX_W-1:0] idx_q;
   logic             done_q;
   logic             pend_q;

   logic [IDX_W-1:0] idx_inc_d;
   logic [W-1:0]     nxt_word_d;
   logic [W-1:0]     word0_cap_d;
   logic [W-1:0]     word0_snap_d;
   logic             xfer;
   logic             frame_end;

   assign xfer         = dvalid_q & D_READY;
   assign idx_inc_d    = idx_q + IDX_W'(1);
   assign nxt_word_d   = pick(snap_q, idx_inc_d);
   assign word0_cap_d  = pick(SNAP_IN, '0);
   assign word0_snap_d = pick(snap_q, '0);

`ifdef PISO_DEB_CHKSUM_EN
   logic [W-1:0] chk_acc;
   logic         chk_clr;
   logic         chk_en;

   // Accumulator only runs in SHIFT, so it is zero again whenever a frame starts.
   assign chk_clr = (state_q != ST_SHIFT) | CLR | ~EN;
   assign chk_en  = (state_q == ST_SHIFT) & xfer;

   piso_deb_chk #(.W(W)) u_chk (
      .clk_i (CLKEXT),
      .rst_i (RST_GLO),
      .clr_i (chk_clr),
      .en_i  (chk_en),
      .din_i (dout_q),
      .acc_o (chk_acc)
   );

   assign frame_end = xfer & (state_q == ST_CHK);
`else
   assign frame_end = xfer & (state_q == ST_SHIFT) & (idx_q == LAST_IDX);
`endif

   always_ff @(posedge CLKEXT or posedge RST_GLO) begin
      if (RST_GLO) begin
         state_q  <= ST_IDLE;
         snap_q   <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else if (CLR) begin
         state_q  <= ST_IDLE;
         snap_q   <= '0;
         dout_q   <= '0;
         dvalid_q <= 1'b0;
         idx_q    <= '0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else if (!EN) begin
         // Snapshot contents stay, but IDLE means a fresh CAPTURE is needed.
         state_q  <= ST_IDLE;
         dvalid_q <= 1'b0;
         done_q   <= 1'b0;
         pend_q   <= 1'b0;
      end else if (frame_end) begin
         done_q <= 1'b1;
         if (CONT_MODE) begin
            snap_q   <= SNAP_IN;
            dout_q   <= word0_cap_d;
            idx_q    <= '0;
            dvalid_q <= 1'b1;
            state_q  <= ST_SHIFT;
         end else begin
            dvalid_q <= 1'b0;
            state_q  <= ST_LOADED;
         end
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (CAPTURE) begin
                  snap_q  <= SNAP_IN;
                  state_q <= ST_LOADED;
                  pend_q  <= START;
               end
            end
            ST_LOADED: begin
               if (CAPTURE) begin
                  snap_q <= SNAP_IN;
               end
               if (START || pend_q) begin
                  dout_q   <= CAPTURE ? word0_cap_d : word0_snap_d;
                  idx_q    <= '0;
                  dvalid_q <= 1'b1;
                  state_q  <= ST_SHIFT;
               end
               pend_q <= 1'b0;
            end
            ST_SHIFT: begin
               if (xfer) begin
                  if (idx_q != LAST_IDX) begin
                     idx_q  <= idx_inc_d;
                     dout_q <= nxt_word_d;
                  end
`ifdef PISO_DEB_CHKSUM_EN
                  else begin
                     idx_q   <= LAST_OUT_IDX;
                     dout_q  <= chk_acc ^ dout_q;
                     state_q <= ST_CHK;
                  end
`endif
               end
            end
            ST_CHK: begin
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign D_OUT    = dout_q;
   assign D_VALID  = dvalid_q;
   assign WORD_IDX = idx_q;
   assign DONE     = done_q;
   assign D_LAST   = dvalid_q & (idx_q == LAST_OUT_IDX);
   assign BUSY     = (state_q == ST_LOADED) | (state_q == ST_SHIFT) | (state_q == ST_CHK);

endmodule
